// File: rtl/mb_level_unpack.sv
// Buffers one 7-beat macroblock record from the encoder FIFO. It then emits one header and the blocks in coding order.
// Optional macro MB_UNPACK_PAD_CHECK_EN adds a sticky error flag for nonzero pad fields in beat 6.
module mb_level_unpack #(
   parameter int DW      = 1024,
   parameter int COEF_W  = 16,
   parameter int MBCNT_W = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [MBCNT_W-1:0]   mb_total,
   input  logic                 fifo_empty,
   output logic                 fifo_rd,
   input  logic [DW-1:0]        fifo_data,
   output logic                 hdr_valid,
   input  logic                 hdr_ready,
   output logic [7:0]           hdr_mbtype,
   output logic [7:0]           hdr_skipped,
   output logic [31:0]          hdr_mode_i16,
   output logic [127:0]         hdr_mode_i4,
   output logic [31:0]          hdr_mode_uv,
   output logic [31:0]          hdr_nz,
   output logic [31:0]          hdr_max_edge,
   output logic [MBCNT_W-1:0]   hdr_mb_idx,
   output logic                 blk_valid,
   input  logic                 blk_ready,
   output logic [16*COEF_W-1:0] blk_data,
   output logic [1:0]           blk_type,
   output logic [3:0]           blk_idx,
   output logic                 blk_last,
   output logic                 busy,
   output logic                 done,
   output logic                 err
);
   localparam int BW = 16 * COEF_W;

   typedef enum logic [2:0] {S_IDLE, S_FETCH, S_HDR, S_BLK, S_FIN} state_t;

   state_t             r_state;
   logic [DW-1:0]      r_beat [0:6];
   logic [2:0]         r_rd_cnt;
   logic [2:0]         r_wr_cnt;
   logic               r_rd_pend;
   logic [4:0]         r_blk_ptr;
   logic [MBCNT_W-1:0] r_mb_cnt;
   logic [MBCNT_W-1:0] r_mb_total;

   logic               w_fifo_rd;
   logic               w_is_i16;
   logic [4:0]         w_seq;
   logic [4:0]         w_y;
   logic [4:0]         w_u;
   logic [4:0]         w_v;
   logic [1:0]         w_blk_type;
   logic [3:0]         w_blk_idx;
   logic [BW-1:0]      w_blk_word;
   logic               w_blk_last;
   logic [MBCNT_W-1:0] w_mb_next;

   assign w_fifo_rd = (r_state == S_FETCH) && !fifo_empty && (r_rd_cnt != 3'd7);
   assign fifo_rd   = w_fifo_rd;
   assign w_mb_next = r_mb_cnt + 1'b1;

   // Data lands one cycle after the pop; store it in the slot of the write counter.
   always_ff @(posedge clk) begin
      if (r_rd_pend && (r_wr_cnt != 3'd7))
         r_beat[r_wr_cnt] <= fifo_data;
   end

   // Walk the I16 sequence (DC, Y0..15, U0..3, V0..3). I4 skips slot 0.
   assign w_is_i16 = r_beat[6][896];
   assign w_seq    = w_is_i16 ? r_blk_ptr : (r_blk_ptr + 5'd1);
   assign w_y      = w_seq - 5'd1;
   assign w_u      = w_seq - 5'd17;
   assign w_v      = w_seq - 5'd21;

   always_comb begin
      w_blk_type = 2'd0;
      w_blk_idx  = 4'd0;
      w_blk_word = r_beat[6][BW-1:0];
      if (w_seq >= 5'd21) begin
         w_blk_type = 2'd3;
         w_blk_idx  = {2'b00, w_v[1:0]};
         w_blk_word = r_beat[5][BW*w_v[1:0] +: BW];
      end else if (w_seq >= 5'd17) begin
         w_blk_type = 2'd2;
         w_blk_idx  = {2'b00, w_u[1:0]};
         w_blk_word = r_beat[4][BW*w_u[1:0] +: BW];
      end else if (w_seq != 5'd0) begin
         w_blk_type = 2'd1;
         w_blk_idx  = w_y[3:0];
         w_blk_word = r_beat[w_y[3:2]][BW*w_y[1:0] +: BW];
      end
   end
   assign w_blk_last = (w_seq == 5'd24);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_rd_cnt   <= 3'd0;
         r_wr_cnt   <= 3'd0;
         r_rd_pend  <= 1'b0;
         r_blk_ptr  <= 5'd0;
         r_mb_cnt   <= '0;
         r_mb_total <= '0;
      end else begin
         r_rd_pend <= w_fifo_rd;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_mb_cnt   <= '0;
                  r_mb_total <= mb_total;
                  r_rd_cnt   <= 3'd0;
                  r_wr_cnt   <= 3'd0;
                  r_state    <= (mb_total == '0) ? S_FIN : S_FETCH;
               end
            end
            S_FETCH: begin
               if (w_fifo_rd) r_rd_cnt <= r_rd_cnt + 3'd1;
               if (r_rd_pend) r_wr_cnt <= r_wr_cnt + 3'd1;
               if (r_wr_cnt == 3'd7) begin
                  r_rd_cnt <= 3'd0;
                  r_wr_cnt <= 3'd0;
                  r_state  <= S_HDR;
               end
            end
            S_HDR: begin
               if (hdr_ready) begin
                  if (r_beat[6][911:904] != 8'd0) begin
                     r_mb_cnt <= w_mb_next;
                     r_state  <= (w_mb_next == r_mb_total) ? S_FIN : S_FETCH;
                  end else begin
                     r_blk_ptr <= 5'd0;
                     r_state   <= S_BLK;
                  end
               end
            end
            S_BLK: begin
               if (blk_ready) begin
                  if (w_blk_last) begin
                     r_mb_cnt <= w_mb_next;
                     r_state  <= (w_mb_next == r_mb_total) ? S_FIN : S_FETCH;
                  end else begin
                     r_blk_ptr <= r_blk_ptr + 5'd1;
                  end
               end
            end
            S_FIN:   r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Data outputs are zeroed outside their channel's state, so reset clears them without clearing the buffer.
   assign hdr_valid    = (r_state == S_HDR);
   assign hdr_mbtype   = hdr_valid ? r_beat[6][903:896] : 8'd0;
   assign hdr_skipped  = hdr_valid ? r_beat[6][911:904] : 8'd0;
   assign hdr_mode_i16 = hdr_valid ? r_beat[6][287:256] : 32'd0;
   assign hdr_mode_i4  = hdr_valid ? r_beat[6][415:288] : 128'd0;
   assign hdr_mode_uv  = hdr_valid ? r_beat[6][447:416] : 32'd0;
   assign hdr_nz       = hdr_valid ? r_beat[6][479:448] : 32'd0;
   assign hdr_max_edge = hdr_valid ? r_beat[6][959:928] : 32'd0;
   assign hdr_mb_idx   = hdr_valid ? r_mb_cnt : '0;

   assign blk_valid = (r_state == S_BLK);
   assign blk_data  = blk_valid ? w_blk_word : '0;
   assign blk_type  = blk_valid ? w_blk_type : 2'd0;
   assign blk_idx   = blk_valid ? w_blk_idx : 4'd0;
   assign blk_last  = blk_valid && w_blk_last;

   assign busy = (r_state != S_IDLE);
   assign done = (r_state == S_FIN);

`ifdef MB_UNPACK_PAD_CHECK_EN
   logic r_err;
   logic w_pad_bad;

   assign w_pad_bad = (|fifo_data[895:480]) | (|fifo_data[927:912]) | (|fifo_data[1023:960]);

   always_ff @(posedge clk) begin
      if (!rst_n)
         r_err <= 1'b0;
      else if ((r_state == S_IDLE) && start)
         r_err <= 1'b0;
      else if (r_rd_pend && (r_wr_cnt == 3'd6) && w_pad_bad)
         r_err <= 1'b1;
   end
   assign err = r_err;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_mb_level_unpack.sv
// Scoreboard bench for mb_level_unpack. Stimulus pushes records and expected headers/blocks.
// A monitor thread checks every handshake against the queues.
`timescale 1ns/1ps
module tb_mb_level_unpack;
   localparam int DW = 1024, COEF_W = 16, MBCNT_W = 16;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 start = 1'b0;
   logic [MBCNT_W-1:0]   mb_total = '0;
   logic                 fifo_empty;
   logic                 fifo_rd;
   logic [DW-1:0]        fifo_data = '0;
   logic                 hdr_valid;
   logic                 hdr_ready = 1'b1;
   logic [7:0]           hdr_mbtype, hdr_skipped;
   logic [31:0]          hdr_mode_i16, hdr_mode_uv, hdr_nz, hdr_max_edge;
   logic [127:0]         hdr_mode_i4;
   logic [MBCNT_W-1:0]   hdr_mb_idx;
   logic                 blk_valid;
   logic                 blk_ready = 1'b1;
   logic [16*COEF_W-1:0] blk_data;
   logic [1:0]           blk_type;
   logic [3:0]           blk_idx;
   logic                 blk_last, busy, done, err;

   mb_level_unpack #(.DW(DW), .COEF_W(COEF_W), .MBCNT_W(MBCNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .mb_total(mb_total),
      .fifo_empty(fifo_empty), .fifo_rd(fifo_rd), .fifo_data(fifo_data),
      .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_mbtype(hdr_mbtype),
      .hdr_skipped(hdr_skipped), .hdr_mode_i16(hdr_mode_i16), .hdr_mode_i4(hdr_mode_i4),
      .hdr_mode_uv(hdr_mode_uv), .hdr_nz(hdr_nz), .hdr_max_edge(hdr_max_edge),
      .hdr_mb_idx(hdr_mb_idx), .blk_valid(blk_valid), .blk_ready(blk_ready),
      .blk_data(blk_data), .blk_type(blk_type), .blk_idx(blk_idx), .blk_last(blk_last),
      .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Encoder FIFO model; a reset flushes it along with the DUT.
   logic [DW-1:0] mem [0:63];
   int   wr_ptr = 0, rd_ptr = 0, pop_cnt = 0;
   logic empty_gap = 1'b0, toggle_en = 1'b0, rand_en = 1'b0;

   assign fifo_empty = (rd_ptr == wr_ptr) || empty_gap;

   always @(posedge clk) begin
      if (!rst_n) begin
         rd_ptr <= wr_ptr;
      end else if (fifo_rd && !fifo_empty) begin
         fifo_data <= mem[rd_ptr[5:0]];
         rd_ptr    <= rd_ptr + 1;
         pop_cnt   <= pop_cnt + 1;
      end
      empty_gap <= toggle_en ? ~empty_gap : 1'b0;
      hdr_ready <= rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
      blk_ready <= rand_en ? ($urandom_range(0, 2) != 0) : 1'b1;
   end

   typedef struct {
      logic [7:0]   mbtype, skipped;
      logic [31:0]  m16, muv, nz, me;
      logic [127:0] m4;
      logic [15:0]  idx;
   } hdr_t;
   typedef struct {
      logic [1:0]   t;
      logic [3:0]   i;
      logic         last;
      logic [255:0] d;
   } blk_t;

   hdr_t exp_hdr[$];
   blk_t exp_blk[$];
   int   checks = 0, errors = 0, done_cnt = 0;
   logic prev_hv = 0, prev_hr = 0, prev_bv = 0, prev_br = 0, prev_done = 0;
   logic [287:0] prev_hsnap = '0;
   logic [262:0] prev_bsnap = '0;

   task automatic chk(input string name, input logic [511:0] got, input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, got, exp);
      end
   endtask

   function automatic logic [255:0] fill(input logic [15:0] v);
      return {16{v}};
   endfunction

   // Y i -> coeffs i, U j -> 0x20+j, V j -> 0x24+j, DC -> 0x00AA.
   task automatic push_mb(input bit i16, input logic [7:0] skip, input bit pad, input logic [15:0] idx);
      logic [4095:0] ac;
      logic [2047:0] uv;
      logic [DW-1:0] b6;
      hdr_t h;
      blk_t b;
      for (int k = 0; k < 16; k++) ac[256*k +: 256] = fill(16'(k));
      for (int j = 0; j < 8; j++)  uv[256*j +: 256] = fill(16'(32 + j));
      b6 = '0;
      b6[255:0]   = fill(16'h00AA);
      b6[287:256] = 32'h1600_0000 | 32'(idx);
      b6[415:288] = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
      b6[447:416] = 32'hC0DE_0000 | 32'(idx);
      b6[479:448] = 32'h0000_FFFF;
      b6[903:896] = i16 ? 8'h03 : 8'h02;
      b6[911:904] = skip;
      b6[959:928] = 32'h0000_0123 + 32'(idx);
      if (pad) b6[500] = 1'b1;
      for (int b2 = 0; b2 < 4; b2++) begin mem[wr_ptr[5:0]] = ac[1024*b2 +: 1024]; wr_ptr++; end
      for (int b2 = 0; b2 < 2; b2++) begin mem[wr_ptr[5:0]] = uv[1024*b2 +: 1024]; wr_ptr++; end
      mem[wr_ptr[5:0]] = b6; wr_ptr++;
      h.mbtype = i16 ? 8'h03 : 8'h02; h.skipped = skip;
      h.m16 = 32'h1600_0000 | 32'(idx); h.m4 = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
      h.muv = 32'hC0DE_0000 | 32'(idx); h.nz = 32'h0000_FFFF; h.me = 32'h0000_0123 + 32'(idx);
      h.idx = idx;
      exp_hdr.push_back(h);
      if (skip == 8'd0) begin
         if (i16) begin b.t = 0; b.i = 0; b.last = 0; b.d = fill(16'h00AA); exp_blk.push_back(b); end
         for (int i = 0; i < 16; i++) begin b.t = 1; b.i = 4'(i); b.last = 0; b.d = fill(16'(i)); exp_blk.push_back(b); end
         for (int j = 0; j < 4; j++) begin b.t = 2; b.i = 4'(j); b.last = 0; b.d = fill(16'(32 + j)); exp_blk.push_back(b); end
         for (int j = 0; j < 4; j++) begin b.t = 3; b.i = 4'(j); b.last = (j == 3); b.d = fill(16'(36 + j)); exp_blk.push_back(b); end
      end
   endtask

   task automatic mon_step();
      logic [287:0] hs;
      logic [262:0] bs;
      hdr_t h;
      blk_t b;
      hs = {hdr_mbtype, hdr_skipped, hdr_mode_i16, hdr_mode_i4, hdr_mode_uv, hdr_nz, hdr_max_edge, hdr_mb_idx};
      bs = {blk_type, blk_idx, blk_last, blk_data};
      if (rst_n) begin
         if (hdr_valid && blk_valid) chk("hdr_blk_excl", 1, 0);
         if (fifo_rd) chk("pop_when_empty", fifo_empty, 0);
         if (prev_hv && !prev_hr) begin chk("hdr_hold", hdr_valid, 1); chk("hdr_stable", hs, prev_hsnap); end
         if (prev_bv && !prev_br) begin chk("blk_hold", blk_valid, 1); chk("blk_stable", bs, prev_bsnap); end
         if (done) begin chk("done_pulse", prev_done, 0); done_cnt++; end
         if (hdr_valid && hdr_ready) begin
            if (exp_hdr.size() == 0) chk("hdr_unexpected", 1, 0);
            else begin
               h = exp_hdr.pop_front();
               chk("hdr_type_skip", {hdr_mbtype, hdr_skipped}, {h.mbtype, h.skipped});
               chk("hdr_modes", {hdr_mode_i16, hdr_mode_i4, hdr_mode_uv}, {h.m16, h.m4, h.muv});
               chk("hdr_nz_edge_idx", {hdr_nz, hdr_max_edge, hdr_mb_idx}, {h.nz, h.me, h.idx});
            end
         end
         if (blk_valid && blk_ready) begin
            if (exp_blk.size() == 0) chk("blk_unexpected", 1, 0);
            else begin
               b = exp_blk.pop_front();
               chk("blk_tag", {blk_type, blk_idx, blk_last}, {b.t, b.i, b.last});
               chk("blk_data", blk_data, b.d);
            end
         end
      end
      prev_hv = rst_n && hdr_valid; prev_hr = hdr_ready; prev_hsnap = hs;
      prev_bv = rst_n && blk_valid; prev_br = blk_ready; prev_bsnap = bs;
      prev_done = rst_n && done;
   endtask

   task automatic check_zero_outputs(input string name);
      chk({name, "_ctrl"}, {fifo_rd, hdr_valid, blk_valid, done, err, busy}, 0);
      chk({name, "_hdr"}, {hdr_mbtype, hdr_skipped, hdr_mode_i16, hdr_mode_i4, hdr_mode_uv, hdr_nz, hdr_max_edge, hdr_mb_idx}, 0);
      chk({name, "_blk"}, {blk_type, blk_idx, blk_last, blk_data}, 0);
   endtask

   task automatic start_frame(input logic [15:0] n);
      @(posedge clk); #1;
      start = 1'b1; mb_total = n;
      @(posedge clk); #1;
      start = 1'b0;
      chk("busy_after_start", busy, 1);
   endtask

   task automatic wait_done(input int budget, input string name);
      int d0 = done_cnt;
      int n = 0;
      while (done_cnt == d0 && n < budget) begin @(posedge clk); #1; n++; end
      chk(name, done_cnt != d0, 1);
      @(posedge clk); #1;
      chk({name, "_queues_empty"}, {exp_hdr.size(), exp_blk.size()}, 0);
   endtask

   task automatic run_tests();
      int p0;
      int n;
      repeat (2) @(posedge clk);
      #1;
      check_zero_outputs("reset_init");
      rst_n = 1'b1;

      // Single I16 MB
      push_mb(1'b1, 8'd0, 1'b0, 16'd0);
      p0 = pop_cnt;
      start_frame(16'd1);
      wait_done(400, "s1_done");
      chk("s1_pops", pop_cnt - p0, 7);
      chk("s1_err", err, 0);

      // Single I4 MB
      push_mb(1'b0, 8'd0, 1'b0, 16'd0);
      p0 = pop_cnt;
      start_frame(16'd1);
      wait_done(400, "s2_done");
      chk("s2_pops", pop_cnt - p0, 7);

      // Two skipped MBs
      push_mb(1'b1, 8'd1, 1'b0, 16'd0);
      push_mb(1'b1, 8'd1, 1'b0, 16'd1);
      p0 = pop_cnt;
      start_frame(16'd2);
      wait_done(400, "s3_done");
      chk("s3_pops", pop_cnt - p0, 14);

      // Gapped FIFO and random backpressure
      toggle_en = 1'b1; rand_en = 1'b1;
      push_mb(1'b1, 8'd0, 1'b0, 16'd0);
      p0 = pop_cnt;
      start_frame(16'd1);
      wait_done(2000, "s4_done");
      chk("s4_pops", pop_cnt - p0, 7);
      toggle_en = 1'b0; rand_en = 1'b0;
      repeat (2) @(posedge clk);

      // Reset in the middle of a fetch
      push_mb(1'b1, 8'd0, 1'b0, 16'd0);
      p0 = pop_cnt;
      start_frame(16'd1);
      n = 0;
      while (pop_cnt - p0 < 3 && n < 50) begin @(posedge clk); #1; n++; end
      chk("s5_three_pops", pop_cnt - p0 >= 3, 1);
      rst_n = 1'b0;
      exp_hdr.delete(); exp_blk.delete();
      @(posedge clk); #1;
      check_zero_outputs("s5_reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      push_mb(1'b0, 8'd0, 1'b0, 16'd0);
      p0 = pop_cnt;
      start_frame(16'd1);
      wait_done(400, "s5_done");
      chk("s5_pops", pop_cnt - p0, 7);

      // Pad bit set, then an empty frame
      push_mb(1'b0, 8'd0, 1'b1, 16'd0);
      p0 = pop_cnt;
      start_frame(16'd1);
      wait_done(400, "s6_done");
`ifdef MB_UNPACK_PAD_CHECK_EN
      chk("s6_err", err, 1);
`else
      chk("s6_err", err, 0);
`endif
      p0 = pop_cnt;
      start_frame(16'd0);
      wait_done(3, "s6_zero_done");
      chk("s6_zero_pops", pop_cnt - p0, 0);
      chk("s6_err_cleared", err, 0);
      chk("s6_idle", busy, 0);
   endtask

   initial begin
      fork
         forever begin @(negedge clk); mon_step(); end
         run_tests();
      join_any
      disable fork;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
